quadrature_gen: RTL and testbench



---
 rtl/quadrature_gen.sv | 159 +++++++++++++++
 tb/tb_quadrature_gen.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quadrature_gen.sv
// rtl/quadrature_gen.sv - quadrature A/B generator driven by detent-move commands
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst_n      asynchronous active-low reset
//   cmd_valid  command present
//   cmd_ready  generator idle; command accepted on cmd_valid && cmd_ready
//   cmd_dir    1 = up (+1 per detent), 0 = down (-1 per detent)
//   cmd_steps  number of detents to emit (0 legal)
//   abort      stop after the detent in progress
//   a_out      quadrature phase A (rest high)
//   b_out      quadrature phase B (rest high)
//   busy       command in progress
//   done       one-clock pulse at command completion
//   position   net detents emitted since reset, two's complement, wraps
module quadrature_gen #(
    parameter int WIDTH        = 8,
    parameter int STEP_WIDTH   = 16,
    parameter int PHASE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_dir,
    input  logic [STEP_WIDTH-1:0] cmd_steps,
    input  logic                  abort,
    output logic                  a_out,
    output logic                  b_out,
    output logic                  busy,
    output logic                  done,
    output logic [WIDTH-1:0]      position
);

    localparam int TW = $clog2(PHASE_CYCLES + 1);
    localparam logic [TW-1:0] T_LAST = TW'(PHASE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        PHASE = 2'd2
    } state_t;

    state_t                state_q;
    logic [TW-1:0]         timer_q;
    logic [1:0]            phase_q;     // index of the next transition within a detent
    logic                  dir_q;
    logic                  abort_q;
    logic [STEP_WIDTH-1:0] remain_q;
    logic                  a_q;
    logic                  b_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  ready_q;
    logic [WIDTH-1:0]      pos_q;

    logic       timer_exp;
    logic       abort_seen;
    logic [1:0] ab_next;

    assign timer_exp  = (timer_q == T_LAST);
    // An abort arriving on the very edge a detent would start still prevents it.
    assign abort_seen = abort_q | abort;

    // A/B level reached by the transition at phase_q.
    // up: 11->10->00->01->11, down: 11->01->00->10->11
    always_comb begin
        ab_next = 2'b11;
        case (phase_q)
            2'd0:    ab_next = dir_q ? 2'b10 : 2'b01;
            2'd1:    ab_next = 2'b00;
            2'd2:    ab_next = dir_q ? 2'b01 : 2'b10;
            default: ab_next = 2'b11;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            phase_q  <= 2'd0;
            dir_q    <= 1'b0;
            abort_q  <= 1'b0;
            remain_q <= '0;
            a_q      <= 1'b1;
            b_q      <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b1;
            pos_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_valid && ready_q) begin
                        dir_q    <= cmd_dir;
                        remain_q <= cmd_steps;
                        abort_q  <= 1'b0;
                        timer_q  <= '0;
                        phase_q  <= 2'd0;
                        busy_q   <= 1'b1;
                        ready_q  <= 1'b0;
                        state_q  <= (cmd_steps == '0) ? HOLD : PHASE;
                    end
                end
                PHASE: begin
                    if (abort) begin
                        abort_q <= 1'b1;
                    end
                    if (!timer_exp) begin
                        timer_q <= timer_q + TW'(1);
                    end else begin
                        timer_q <= '0;
                        if (phase_q == 2'd0 && abort_seen) begin
                            // Lines already rested at 11 for P clocks: that is the hold.
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            ready_q <= 1'b1;
                            state_q <= IDLE;
                        end else begin
                            a_q     <= ab_next[1];
                            b_q     <= ab_next[0];
                            phase_q <= phase_q + 2'd1;
                            if (phase_q == 2'd3) begin
                                pos_q <= dir_q ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
                                if (remain_q != '0) begin
                                    remain_q <= remain_q - STEP_WIDTH'(1);
                                end
                                if (remain_q <= STEP_WIDTH'(1)) begin
                                    state_q <= HOLD;
                                end
                            end
                        end
                    end
                end
                HOLD: begin
                    if (timer_exp) begin
                        timer_q <= '0;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;
    assign position  = pos_q;

endmodule

// File: tb/tb_quadrature_gen.sv
// tb/tb_quadrature_gen.sv - self-checking bench for quadrature_gen
module tb_quadrature_gen;

    localparam int P   = 4;
    localparam int W   = 8;
    localparam int SW  = 16;
    localparam int INF = 32'h3fff_ffff;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_dir;
    logic [SW-1:0] cmd_steps;
    logic          abort;
    logic          a_out;
    logic          b_out;
    logic          busy;
    logic          done;
    logic [W-1:0]  position;

    quadrature_gen #(.WIDTH(W), .STEP_WIDTH(SW), .PHASE_CYCLES(P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_dir   (cmd_dir),
        .cmd_steps (cmd_steps),
        .abort     (abort),
        .a_out     (a_out),
        .b_out     (b_out),
        .busy      (busy),
        .done      (done),
        .position  (position)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;

    // Reference model: one command described by its accept time and parameters.
    bit           m_active;
    bit           m_done;
    bit           m_dir;
    int           m_t;
    int           m_n;
    int           m_ta;
    logic [W-1:0] m_pos0;
    logic [W-1:0] m_pos;
    logic [W-1:0] e_pos;

    // Bench-side quadrature decoder fed from the DUT pins.
    logic [W-1:0] dec_cnt;
    logic         prev_a;
    logic         prev_b;
    int           edge_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Detents whose first transition edge (4k+1)P lies before the abort edge.
    function automatic int n_lim(input int ta);
        if (ta <= P) return 0;
        return (ta - P - 1) / (4 * P) + 1;
    endfunction

    function automatic logic [1:0] level(input bit up, input int i);
        case (i)
            1:       return up ? 2'b10 : 2'b01;
            2:       return 2'b00;
            3:       return up ? 2'b01 : 2'b10;
            default: return 2'b11;
        endcase
    endfunction

    task automatic model_reset();
        m_active = 0; m_done = 0; m_pos = '0; e_pos = '0;
        dec_cnt = '0; prev_a = 1'b1; prev_b = 1'b1;
    endtask

    task automatic step();
        bit          v, d, ab;
        int          s, ne, tr;
        logic [1:0]  eab;
        v = cmd_valid; d = cmd_dir; s = int'(cmd_steps); ab = abort;
        @(posedge clk);
        cyc++;
        m_done = 0;
        if (m_active) begin
            m_t++;
            if (ab && m_ta == INF) m_ta = m_t;
        end else if (v && rst_n) begin
            m_active = 1; m_t = 0; m_n = s; m_dir = d; m_ta = INF; m_pos0 = m_pos;
        end
        eab   = 2'b11;
        e_pos = m_pos;
        if (m_active) begin
            ne = (m_n < n_lim(m_ta)) ? m_n : n_lim(m_ta);
            tr = (m_t / P < 4 * ne) ? m_t / P : 4 * ne;
            eab = level(m_dir, tr % 4);
            e_pos = m_dir ? m_pos0 + W'(tr / 4) : m_pos0 - W'(tr / 4);
            if (m_t == 4 * ne * P + P) begin
                m_done = 1; m_active = 0; m_pos = e_pos;
            end
        end
        @(negedge clk);
        chk("ab",    32'({a_out, b_out}), 32'(eab));
        chk("busy",  32'(busy),      32'(m_active));
        chk("done",  32'(done),      32'(m_done));
        chk("ready", 32'(cmd_ready), 32'(!m_active));
        chk("pos",   32'(position),  32'(e_pos));
        if (!prev_a && a_out) dec_cnt = b_out ? dec_cnt + W'(1) : dec_cnt - W'(1);
        if (a_out !== prev_a) edge_cnt++;
        if (b_out !== prev_b) edge_cnt++;
        prev_a = a_out; prev_b = b_out;
        if (m_done) chk("decoder", 32'(dec_cnt), 32'(position));
    endtask

    task automatic steps_n(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input bit dir, input int n);
        cmd_valid = 1'b1; cmd_dir = dir; cmd_steps = SW'(n);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int maxc);
        int c;
        c = 0;
        while (m_active && c < maxc) begin step(); c++; end
        if (m_active) chk("timeout", 32'd1, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; abort = 1'b0;
        edge_cnt = 0;
        model_reset();
        steps_n(2);
        chk("rst_ab",    32'({a_out, b_out}), 32'(2'b11));
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        rst_n = 1'b1;
        steps_n(2);

        // 1 up: literal waveform points relative to E0
        issue(1'b1, 1);
        steps_n(4);  chk("t1_ab4",  32'({a_out, b_out}), 32'(2'b10));
        steps_n(4);  chk("t1_ab8",  32'({a_out, b_out}), 32'(2'b00));
        steps_n(4);  chk("t1_ab12", 32'({a_out, b_out}), 32'(2'b01));
        steps_n(4);  chk("t1_ab16", 32'({a_out, b_out}), 32'(2'b11));
        chk("t1_pos", 32'(position), 32'h01);
        steps_n(4);  chk("t1_done20", 32'(done), 32'd1);
        steps_n(2);

        // 3 down, with a conflicting command held while busy
        edge_cnt = 0;
        issue(1'b0, 3);
        cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_steps = 16'd7;
        steps_n(10);
        cmd_valid = 1'b0;
        steps_n(42);
        chk("t2_done52", 32'(done), 32'd1);
        chk("t2_pos",    32'(position), 32'hFE);
        chk("t2_edges",  32'(edge_cnt), 32'd12);
        steps_n(1);

        // zero steps
        edge_cnt = 0;
        issue(1'b1, 0);
        steps_n(4);
        chk("t3_done4",  32'(done), 32'd1);
        chk("t3_edges",  32'(edge_cnt), 32'd0);
        chk("t3_pos",    32'(position), 32'hFE);
        steps_n(1);

        // abort inside the second detent
        issue(1'b1, 10);
        steps_n(21);
        abort = 1'b1; step(); abort = 1'b0;
        steps_n(10);
        chk("t4_ab32",  32'({a_out, b_out}), 32'(2'b11));
        chk("t4_pos",   32'(position), 32'h00);
        steps_n(4);
        chk("t4_done36", 32'(done), 32'd1);
        abort = 1'b1; steps_n(3); abort = 1'b0;   // ignored in IDLE
        steps_n(1);

        // wrap around both ways
        issue(1'b1, 127);
        run_until_idle(3000);
        chk("wrap_127", 32'(position), 32'h7F);
        issue(1'b1, 1);
        run_until_idle(100);
        chk("wrap_m128", 32'(position), 32'h80);
        issue(1'b0, 1);
        run_until_idle(100);
        chk("wrap_back", 32'(position), 32'h7F);

        // asynchronous reset mid-detent
        issue(1'b1, 1);
        steps_n(8);
        chk("rst_mid_pre", 32'({a_out, b_out}), 32'(2'b00));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ab",   32'({a_out, b_out}), 32'(2'b11));
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_pos",  32'(position), 32'h00);
        model_reset();
        steps_n(2);
        rst_n = 1'b1;
        steps_n(1);

        // random commands, decoder checked against position at each done
        for (int i = 0; i < 25; i++) begin
            int ta;
            ta = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 60)) : INF;
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            for (int c = 0; c < 200 && m_active; c++) begin
                abort = (m_t + 1 == ta);
                cmd_valid = 1'($urandom_range(0, 1));
                step();
            end
            abort = 1'b0; cmd_valid = 1'b0;
            if (m_active) chk("rand_timeout", 32'd1, 32'd0);
            steps_n(int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
